// File: rtl/datainf_master_burst_gen_pkg.sv
// datainf_gen_pkg: shared FSM state type and LFSR helpers for the data_inf
// burst generator. The LFSR items are only referenced when the payload LFSR
// option (DATAINF_BURST_GEN_LFSR_EN) is compiled in.
package datainf_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } gen_state_t;

  // Maximal-length Fibonacci tap masks (bit i set = register bit i feeds XOR).
  // 8 : x^8+x^6+x^5+x^4+1
  // 16: x^16+x^15+x^13+x^4+1
  // 32: x^32+x^22+x^2+x+1
  localparam logic [31:0] LFSR_TAPS_8  = 32'h0000_00B8;
  localparam logic [31:0] LFSR_TAPS_16 = 32'h0000_D008;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  // One Fibonacci step: shift left, XOR of tapped bits enters at bit 0.
  // Unsupported widths fall back to the 8-bit polynomial.
  function automatic logic [31:0] next_lfsr(input logic [31:0] value, input int width);
    logic [31:0] taps;
    logic [31:0] mask;
    logic        fb;
    case (width)
      16:      taps = LFSR_TAPS_16;
      32:      taps = LFSR_TAPS_32;
      default: taps = LFSR_TAPS_8;
    endcase
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
    fb   = ^(value & taps);
    return ((value << 1) | {31'd0, fb}) & mask;
  endfunction

endpackage

// File: rtl/datainf_master_burst_gen_if.sv
// data_inf: valid/ready/data stream interface shared by masters and slavers.
interface data_inf #(
  parameter int DSIZE = 8
) ();
  logic             valid;
  logic             ready;
  logic [DSIZE-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/datainf_master_burst_gen_lfsr.sv
// datainf_lfsr: payload LFSR for the burst generator. Present only when
// DATAINF_BURST_GEN_LFSR_EN is defined; a zero seed is forced to 1 so the
// register can never lock up in the all-zero state.
`ifdef DATAINF_BURST_GEN_LFSR_EN
module datainf_lfsr
  import datainf_gen_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DSIZE-1:0] seed,
  input  logic             step,
  output logic [DSIZE-1:0] value
);

  logic [DSIZE-1:0] r_value;
  logic [31:0]      w_next;

  assign w_next = next_lfsr(32'(r_value), DSIZE);
  assign value  = r_value;

  // Load the seed on burst start, advance once per accepted beat.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
    end else if (load) begin
      r_value <= (seed == '0) ? DSIZE'(1) : seed;
    end else if (step) begin
      r_value <= w_next[DSIZE-1:0];
    end
  end

endmodule
`endif

// File: rtl/datainf_master_burst_gen.sv
// datainf_master_burst_gen: drives a data_inf master port with a burst of
// 'length' beats per accepted start. Payload increments from 'seed', or
// follows an LFSR when DATAINF_BURST_GEN_LFSR_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; while r_busy is still set this is the done-pulse
//       | cycle and start is not accepted
// SEND  | valid high, counting handshakes down to the last beat
// DONE  | burst finished (valid low); done pulses on the next cycle
module datainf_master_burst_gen
  import datainf_gen_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int LSIZE = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LSIZE-1:0] length,
  input  logic [DSIZE-1:0] seed,
  output logic             busy,
  output logic             done,
  output logic [LSIZE-1:0] beat_cnt,
  data_inf.master          master
);

  gen_state_t       r_state;
  logic [LSIZE-1:0] r_remaining;
  logic [LSIZE-1:0] r_beat_cnt;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic             w_hs;
  logic             w_accept;
  logic [DSIZE-1:0] w_data;

  assign w_hs     = r_valid & master.ready;
  assign w_accept = (r_state == IDLE) & start & ~r_busy;

  assign master.valid = r_valid;
  assign master.data  = w_data;
  assign busy         = r_busy;
  assign done         = r_done;
  assign beat_cnt     = r_beat_cnt;

  // Burst sequencing FSM with registered valid/busy/done/beat count.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_beat_cnt  <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_busy <= 1'b0;
          if (w_accept) begin
            r_busy      <= 1'b1;
            r_beat_cnt  <= '0;
            r_remaining <= length;
            if (length != '0) begin
              r_valid <= 1'b1;
              r_state <= SEND;
            end else begin
              r_state <= DONE;
            end
          end
        end
        SEND: begin
          if (w_hs) begin
            r_beat_cnt  <= r_beat_cnt + LSIZE'(1);
            r_remaining <= r_remaining - LSIZE'(1);
            if (r_remaining == LSIZE'(1)) begin
              r_valid <= 1'b0;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef DATAINF_BURST_GEN_LFSR_EN
  datainf_lfsr #(
    .DSIZE(DSIZE)
  ) u_lfsr (
    .clock (clock),
    .rst_n (rst_n),
    .load  (w_accept),
    .seed  (seed),
    .step  (w_hs),
    .value (w_data)
  );
`else
  logic [DSIZE-1:0] r_data;

  assign w_data = r_data;

  // Incrementing payload: seed on accepted start, +1 per handshake (wraps).
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (w_accept) begin
      r_data <= seed;
    end else if (w_hs) begin
      r_data <= r_data + DSIZE'(1);
    end
  end
`endif

endmodule

// File: tb/tb_datainf_master_burst_gen.sv
// Testbench for datainf_master_burst_gen (DSIZE=8, LSIZE=16). Expected beats
// and done timing come from a cycle-level model of the burst rules; the
// payload model follows DATAINF_BURST_GEN_LFSR_EN when it is defined.
module tb_datainf_master_burst_gen;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] length;
  logic [7:0]  seed;
  logic        busy;
  logic        done;
  logic [15:0] beat_cnt;
  int          checks   = 0;
  int          failures = 0;

  data_inf #(.DSIZE(8)) bus ();

  datainf_master_burst_gen #(
    .DSIZE(8),
    .LSIZE(16)
  ) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .start    (start),
    .length   (length),
    .seed     (seed),
    .busy     (busy),
    .done     (done),
    .beat_cnt (beat_cnt),
    .master   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Payload of beat n of a burst started with seed sd.
  function automatic logic [7:0] exp_data(input logic [7:0] sd, input int n);
`ifdef DATAINF_BURST_GEN_LFSR_EN
    logic [7:0] s;
    s = (sd == 8'h00) ? 8'h01 : sd;
    for (int i = 0; i < n; i++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    return s;
`else
    return sd + 8'(n);
`endif
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // mode 0: ready=1; 1: ready 1,0,0 repeating; 2: random ready;
  // 3: ready=1 with a stray start pulse mid-burst.
  task automatic run_burst(input int len, input logic [7:0] sd, input int mode);
    int   got, cyc, last_hs, bound;
    bit   exp_done, seen_done;
    logic r;
    start    = 1'b1;
    length   = 16'(len);
    seed     = sd;
    bus.ready = 1'($urandom_range(0, 1));
    step();
    start   = 1'b0;
    length  = 16'($urandom);
    seed    = 8'($urandom);
    got     = 0;
    cyc     = 1;
    last_hs = 0;
    seen_done = 1'b0;
    bound   = len * 4 + 12;
    while (!seen_done && cyc < bound) begin
      exp_done = (got == len) && (cyc == last_hs + 2);
      chk("valid", 32'(bus.valid), 32'(got < len));
      if (got < len) chk("data", 32'(bus.data), 32'(exp_data(sd, got)));
      chk("busy", 32'(busy), 32'd1);
      chk("beat_cnt", 32'(beat_cnt), 32'(got));
      chk("done", 32'(done), 32'(exp_done));
      seen_done = exp_done | done;
      case (mode)
        0, 3:    r = 1'b1;
        1:       r = ((cyc - 1) % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.ready = r;
      start     = (mode == 3) && (cyc == 2);
      if (start) length = 16'd7;
      if (got < len && r) begin
        got++;
        last_hs = cyc;
      end
      if (!seen_done) begin
        step();
        cyc++;
      end
    end
    start = 1'b0;
    chk("done_reached", 32'(seen_done), 32'd1);
    if (mode == 0 || mode == 3) chk("done_latency", 32'(cyc), 32'(len + 2));
    step();
    chk("post_done", 32'(done), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_valid", 32'(bus.valid), 32'd0);
    chk("post_beat_cnt", 32'(beat_cnt), 32'(len));
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    length    = '0;
    seed      = '0;
    bus.ready = 1'b0;
    step();
    step();
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_data", 32'(bus.data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    rst_n = 1'b1;
    step();

    run_burst(4, 8'h10, 0);
    run_burst(3, 8'h5A, 1);
    run_burst(0, 8'h77, 0);
    run_burst(3, 8'hFE, 0);
    run_burst(5, 8'h21, 3);
    run_burst(20, 8'($urandom), 0);
    for (int i = 0; i < 8; i++) run_burst(int'($urandom_range(0, 12)), 8'($urandom), 2);

    // Reset asserted after beat 2 of 5: valid drops at once, no done follows.
    start     = 1'b1;
    length    = 16'd5;
    seed      = 8'h40;
    bus.ready = 1'b1;
    step();
    start = 1'b0;
    chk("rb_data0", 32'(bus.data), 32'h40);
    step();
    chk("rb_data1", 32'(bus.data), 32'h41);
    step();
    chk("rb_beat_cnt", 32'(beat_cnt), 32'd2);
    chk("rb_valid_pre", 32'(bus.valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rb_valid_async", 32'(bus.valid), 32'd0);
    chk("rb_busy_async", 32'(busy), 32'd0);
    chk("rb_beat_async", 32'(beat_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("rb_no_done", 32'(done), 32'd0);
      chk("rb_no_valid", 32'(bus.valid), 32'd0);
      step();
    end
    run_burst(5, 8'h40, 0);

`ifdef DATAINF_BURST_GEN_LFSR_EN
    run_burst(255, 8'h00, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datainf_master_burst_gen.md
Name: datainf_master_burst_gen

Overview:
- Master-side counterpart to the always-ready slaver terminator.
- Drives a data_inf master port with a programmable burst of LEN beats once per start request.
- Strict valid/ready handshake; payload is an incrementing sequence from a seed.
- Used as a bench stimulus source and as a bring-up traffic generator ahead of data_inf sinks, FIFOs and width converters.

Parameters:
DSIZE, 8, payload width of master.data.
LSIZE, 16, width of the length input and beat counter.

Ports:
clock  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request; sampled only in IDLE.
length  input  LSIZE  beats in burst; sampled with start.
seed  input  DSIZE  first payload value; sampled with start.
busy  output  1  high from accepted start until done pulse inclusive.
done  output  1  one-cycle pulse, burst complete.
beat_cnt  output  LSIZE  handshakes completed in current/last burst.
master.valid  output  1  data_inf valid.
master.ready  input  1  data_inf ready from downstream slaver.
master.data  output  DSIZE  data_inf payload.

Behaviour:
- Interface: one clock (clock); reset rst_n is asynchronous and active-low.
- Reset values: valid=0, data=0, busy=0, done=0, beat_cnt=0, state=IDLE. Assertion mid-burst drops valid immediately (async); the burst is abandoned with no done pulse.
- FSM IDLE -> SEND -> DONE -> IDLE.
- IDLE: on start with length!=0, latch remaining=length, data=seed, beat_cnt=0, busy=1; next cycle valid=1 (latency start->valid = 1 clk).
- IDLE: start with length==0 -> DONE directly; done pulses the following cycle with beat_cnt=0 and no beats issued.
- SEND: handshake = valid & ready.
  - On handshake: beat_cnt+1, data+1 (wraps mod 2^DSIZE), remaining-1.
  - When the last beat handshakes, valid falls next cycle -> DONE.
  - Without a handshake, valid and data hold stable; valid never deasserts before acceptance.
  - ready may be high while valid is low; this has no effect.
- DONE: done=1 for exactly one cycle, busy=1 in that cycle, then IDLE with busy=0. beat_cnt holds until the next accepted start.
- start outside IDLE (SEND/DONE) is ignored; no queuing.
- Back-to-back: start asserted in the cycle after done is accepted; minimum inter-burst gap is 1 idle cycle.
- Full throughput: ready held high gives 1 beat/clk; an N-beat burst takes N+2 cycles from start to done.
- length of all ones (2^LSIZE-1) is legal; counter arithmetic is LSIZE-bit unsigned with no overflow by construction.

Optional Feature:
Macro DATAINF_BURST_GEN_LFSR_EN.
- Defined: payload is a maximal-length Fibonacci LFSR seeded with seed. A zero seed is forced to 1. The LFSR advances on each handshake instead of incrementing.
- Not defined: incrementing payload only; no LFSR logic is synthesised.
- Handshake, timing and counters are identical in both builds.

Decomposition:
- Package datainf_gen_pkg holds:
  - state enum gen_state_t {IDLE, SEND, DONE};
  - LFSR tap constants per DSIZE (8, 16, 32);
  - a function next_lfsr(value) selecting taps by width.
- Sub-module datainf_lfsr (clock, rst_n, load, seed, step, value) is the natural split. It is instantiated only under DATAINF_BURST_GEN_LFSR_EN.

Test Plan:
- ready=1 constant, start with length=4, seed=8'h10 -> data 10,11,12,13 on 4 consecutive clocks; done at cycle 6 after start; beat_cnt=4.
- ready toggling 1,0,0,1,... with length=3 -> valid stays high through stalls, data held constant while ready=0, exactly 3 handshakes, done once.
- length=0, start -> no valid asserted; done pulses 2 cycles after start; beat_cnt=0.
- seed=8'hFE, length=3 -> data FE, FF, 00 (wrap).
- start pulsed again mid-burst, and rst_n dropped after beat 2 of 5 -> second start ignored; after reset, valid=0 immediately, no done pulse, and the next start runs normally.
- LFSR build: seed=0, length=255, DSIZE=8 -> first beat 8'h01, 255 distinct nonzero values, no repeat.
